// File: rtl/delay_cal_if.sv
// Request/measurement bundle between the delay-line calibrator and its user/delay line.
interface delay_cal_if #(
  parameter int TAP_W = 4,
  parameter int CNT_W = 6
);
  logic             i_start;
  logic             i_arrive;
  logic             o_launch;
  logic [TAP_W-1:0] o_tap;
  logic [CNT_W-1:0] o_lat;
  logic             o_busy;
  logic             o_lock;
  logic             o_fail;
  logic             o_done;

  modport master (
    output i_start, i_arrive,
    input  o_launch, o_tap, o_lat, o_busy, o_lock, o_fail, o_done
  );

  modport slave (
    input  i_start, i_arrive,
    output o_launch, o_tap, o_lat, o_busy, o_lock, o_fail, o_done
  );
endinterface

// File: rtl/delay_cal_ctrl.sv
// Delay-line calibrator: steps the tap select upward until a launched edge takes
// at least TARGET cycles to come back, flagging stuck-high, timeout or tap exhaustion.
module delay_cal_ctrl #(
  parameter int TAP_W   = 4,
  parameter int CNT_W   = 6,
  parameter int SETTLE  = 4,
  parameter int TARGET  = 5,
  parameter int TIMEOUT = 32
) (
  input logic        i_clk,
  input logic        i_rst,
  delay_cal_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LAUNCH, S_MEASURE, S_DONE, S_FAIL
  } state_t;

  localparam logic [TAP_W-1:0] TAP_MAX     = {TAP_W{1'b1}};
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TARGET_C    = CNT_W'(TARGET);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [TAP_W-1:0] tap_reg, tap_next;
  logic [CNT_W-1:0] lat_reg, lat_next;
  logic             lock_reg, lock_next;
  logic             fail_reg, fail_next;
  logic             launch_reg, launch_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] idx;

  // MEASURE cycles are numbered from 1; TIMEOUT < 2^CNT_W keeps this from wrapping.
  assign idx = cnt_reg + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      tap_reg    <= '0;
      lat_reg    <= '0;
      lock_reg   <= 1'b0;
      fail_reg   <= 1'b0;
      launch_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      tap_reg    <= tap_next;
      lat_reg    <= lat_next;
      lock_reg   <= lock_next;
      fail_reg   <= fail_next;
      launch_reg <= launch_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (bus.i_start) state_next = S_SETTLE;
      S_SETTLE:  if (cnt_reg == SETTLE_LAST) state_next = bus.i_arrive ? S_FAIL : S_LAUNCH;
      S_LAUNCH:  state_next = S_MEASURE;
      S_MEASURE: begin
        if (bus.i_arrive) begin
          if (idx >= TARGET_C)       state_next = S_DONE;
          else if (tap_reg == TAP_MAX) state_next = S_FAIL;
          else                       state_next = S_SETTLE;
        end else if (idx == TIMEOUT_C) begin
          state_next = S_FAIL;
        end
      end
      S_DONE:    state_next = S_IDLE;
      S_FAIL:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so the registered copies line up with it.
  always_comb begin
    cnt_next  = cnt_reg;
    tap_next  = tap_reg;
    lat_next  = lat_reg;
    lock_next = lock_reg;
    fail_next = fail_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.i_start) begin
          cnt_next  = '0;
          tap_next  = '0;
          lock_next = 1'b0;
          fail_next = 1'b0;
        end
      end
      S_SETTLE:  cnt_next = (cnt_reg == SETTLE_LAST) ? '0 : cnt_reg + CNT_W'(1);
      S_LAUNCH:  cnt_next = '0;
      S_MEASURE: begin
        cnt_next = idx;
        if (bus.i_arrive) begin
          lat_next = idx;
          if (state_next == S_SETTLE) begin
            tap_next = tap_reg + TAP_W'(1);
            cnt_next = '0;
          end
        end else if (idx == TIMEOUT_C) begin
          lat_next = TIMEOUT_C;
        end
      end
      default: ;
    endcase
    if (state_next == S_DONE) lock_next = 1'b1;
    if (state_next == S_FAIL) fail_next = 1'b1;
    launch_next = (state_next == S_LAUNCH) || (state_next == S_MEASURE);
    busy_next   = (state_next != S_IDLE);
    done_next   = (state_next == S_DONE) || (state_next == S_FAIL);
  end

  assign bus.o_launch = launch_reg;
  assign bus.o_tap    = tap_reg;
  assign bus.o_lat    = lat_reg;
  assign bus.o_busy   = busy_reg;
  assign bus.o_lock   = lock_reg;
  assign bus.o_fail   = fail_reg;
  assign bus.o_done   = done_reg;
endmodule

// File: tb/tb_delay_cal_ctrl.sv
// Calibrator bench: a shift-register delay line closes the loop, a queue of predicted
// calibration results is drained by a monitor whenever the DUT reports done.
module tb_delay_cal_ctrl;
  localparam int TAP_W   = 4;
  localparam int CNT_W   = 6;
  // Settle window long enough that the return pulse of every delay used here drains first.
  localparam int SETTLE  = 8;
  localparam int TARGET  = 5;
  localparam int TIMEOUT = 32;
  localparam int NTAPS   = 1 << TAP_W;

  localparam int M_LINEAR = 0;
  localparam int M_FIXED  = 1;
  localparam int M_STUCK0 = 2;
  localparam int M_STUCK1 = 3;

  typedef struct {
    int lock;
    int fail;
    int tap;
    int lat;
    int launches;
    int high;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_cal_if #(.TAP_W(TAP_W), .CNT_W(CNT_W)) bus ();

  delay_cal_ctrl #(
    .TAP_W(TAP_W), .CNT_W(CNT_W), .SETTLE(SETTLE), .TARGET(TARGET), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];
  int dl_mode  = M_FIXED;
  int dl_param = 1;
  int model_lat = 0;
  int cal_no = 0;

  // Delay line: arrive is launch delayed by D flops, D chosen by the current tap.
  logic [NTAPS-1:0] dl = '0;
  logic arrive;
  int   d_sel;
  always @(posedge clk) dl <= {dl[NTAPS-2:0], bus.o_launch};
  always_comb begin
    d_sel = (dl_mode == M_LINEAR) ? int'(bus.o_tap) + dl_param : dl_param;
    if (d_sel > NTAPS) d_sel = NTAPS;
    if (d_sel < 1) d_sel = 1;
    case (dl_mode)
      M_STUCK0: arrive = 1'b0;
      M_STUCK1: arrive = 1'b1;
      default:  arrive = dl[d_sel-1];
    endcase
  end
  assign bus.i_arrive = arrive;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Walks the tap search with arithmetic on pulse lengths rather than cycle by cycle.
  function automatic exp_t model(input int mode, input int prm, input int prev_lat);
    exp_t e;
    int tap = 0;
    int prev_l = -1;
    int d;
    e = '{lock: 0, fail: 0, tap: 0, lat: prev_lat, launches: 0, high: 0};
    for (int g = 0; g < 4 * NTAPS; g++) begin
      d = (mode == M_LINEAR) ? tap + prm : prm;
      if (d > NTAPS) d = NTAPS;
      // Previous return pulse still high at the end of the settle window -> stuck.
      if (mode == M_STUCK1 || (prev_l >= 0 && d >= SETTLE && d <= SETTLE + prev_l)) begin
        e.fail = 1;
        break;
      end
      e.launches++;
      if (mode == M_STUCK0 || d > TIMEOUT) begin
        e.high += TIMEOUT + 1;
        e.lat = TIMEOUT;
        e.fail = 1;
        break;
      end
      e.high += d + 1;
      e.lat = d;
      if (d >= TARGET) begin
        e.lock = 1;
        break;
      end
      if (tap == NTAPS - 1) begin
        e.fail = 1;
        break;
      end
      tap++;
      prev_l = d;
    end
    e.tap = tap;
    return e;
  endfunction

  // Monitor: counts launches and compares the settled result the cycle after o_done.
  initial begin
    int mon_high = 0;
    int mon_launches = 0;
    bit prev_launch = 0;
    bit done_prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_high = 0; mon_launches = 0; prev_launch = 0; done_prev = 0;
      end else begin
        if (done_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            cal_no++;
            $display("cal %0d: tap=%0d lat=%0d lock=%0d fail=%0d launches=%0d high=%0d (exp tap=%0d lat=%0d lock=%0d fail=%0d launches=%0d high=%0d)",
                     cal_no, bus.o_tap, bus.o_lat, bus.o_lock, bus.o_fail, mon_launches, mon_high,
                     e.tap, e.lat, e.lock, e.fail, e.launches, e.high);
            check("res_tap", int'(bus.o_tap), e.tap);
            check("res_lat", int'(bus.o_lat), e.lat);
            check("res_lock", int'(bus.o_lock), e.lock);
            check("res_fail", int'(bus.o_fail), e.fail);
            check("res_launches", mon_launches, e.launches);
            check("res_launch_cycles", mon_high, e.high);
            check("res_busy_after", int'(bus.o_busy), 0);
          end
          mon_high = 0;
          mon_launches = 0;
        end
        if (bus.o_launch) begin
          mon_high++;
          if (!prev_launch) mon_launches++;
        end
        prev_launch = bus.o_launch;
        if (bus.o_done && done_prev) check("done_width", 2, 1);
        done_prev = bus.o_done;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_launch"}, int'(bus.o_launch), 0);
    check({tag, "_tap"}, int'(bus.o_tap), 0);
    check({tag, "_lat"}, int'(bus.o_lat), 0);
    check({tag, "_busy"}, int'(bus.o_busy), 0);
    check({tag, "_lock"}, int'(bus.o_lock), 0);
    check({tag, "_fail"}, int'(bus.o_fail), 0);
    check({tag, "_done"}, int'(bus.o_done), 0);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_done) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  // One calibration: predict, start, optionally hold start or poke it while busy.
  task automatic run_cal(input int mode, input int prm, input bit hold, input bit poke);
    exp_t e;
    dl_mode = mode;
    dl_param = prm;
    e = model(mode, prm, model_lat);
    exp_q.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    check("accept_busy", int'(bus.o_busy), 1);
    check("accept_lock_clr", int'(bus.o_lock), 0);
    check("accept_fail_clr", int'(bus.o_fail), 0);
    if (!hold) bus.i_start = 1'b0;
    if (poke) begin
      repeat (2) @(negedge clk);
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    wait_done();
    bus.i_start = 1'b0;
    model_lat = e.lat;
    repeat (40) @(negedge clk);
  endtask

  task automatic run_reset_mid();
    exp_t e;
    bit seen = 0;
    dl_mode = M_LINEAR;
    dl_param = 1;
    e = model(M_LINEAR, 1, model_lat);
    exp_q.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_launch && bus.o_tap == TAP_W'(3)) seen = 1;
    end
    if (!seen) check("reach_measure_timeout", 0, 1);
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    model_lat = 0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    run_cal(M_LINEAR, 1, 1'b0, 1'b0);
    run_cal(M_FIXED, 2, 1'b0, 1'b0);
    run_cal(M_STUCK1, 0, 1'b0, 1'b0);
    run_cal(M_STUCK0, 0, 1'b0, 1'b0);
    run_reset_mid();
    run_cal(M_LINEAR, 1, 1'b0, 1'b0);
    run_cal(M_LINEAR, 1, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int mode;
      int prm;
      mode = int'($urandom_range(0, 3));
      prm  = (mode == M_LINEAR) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, SETTLE));
      run_cal(mode, prm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/delay_cal_ctrl.md
DELAY_CAL_CTRL -- requirements
Module: delay_cal_ctrl

Interface
REQ-001 SHALL have parameter TAP_W, 4, width of delay-line tap select (2^TAP_W taps).
REQ-002 SHALL have parameter CNT_W, 6, width of latency counter and o_lat.
REQ-003 SHALL have parameter SETTLE, 4, idle cycles before each launch.
REQ-004 SHALL have parameter TARGET, 5, minimum acceptable latency in cycles.
REQ-005 SHALL have parameter TIMEOUT, 32, maximum MEASURE cycles before failure; legal only with TARGET < TIMEOUT < 2^CNT_W.
REQ-006 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port i_start  input  1  calibration request, sampled in IDLE only.
REQ-009 SHALL have port i_arrive  input  1  delay-line output, pre-synchronized to i_clk.
REQ-010 SHALL have port o_launch  output  1  test edge driven into delay-line input.
REQ-011 SHALL have port o_tap  output  TAP_W  tap select driven to delay line.
REQ-012 SHALL have port o_lat  output  CNT_W  latency of the most recent measurement.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port o_lock  output  1  level; calibration succeeded.
REQ-015 SHALL have port o_fail  output  1  level; calibration failed.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse at the end of any calibration.

Function
REQ-017 SHALL implement states IDLE, SETTLE, LAUNCH, MEASURE, DONE, FAIL; all outputs registered.
REQ-018 IDLE: i_start=1 -> SETTLE; o_tap<=0, cnt<=0, o_lock<=0, o_fail<=0 in the same edge.
REQ-019 SETTLE: o_launch=0; count SETTLE cycles; on the last one, i_arrive=0 -> LAUNCH, i_arrive=1 -> FAIL (stuck-high).
REQ-020 o_launch SHALL be 1 exactly in cycles whose state is LAUNCH or MEASURE; 0 otherwise.
REQ-021 LAUNCH: lasts one cycle; clears cnt; -> MEASURE.
REQ-022 MEASURE: cycles are indexed 1,2,...; the first cycle with i_arrive=1 at index L SHALL load o_lat<=L.
REQ-023 On arrival with L>=TARGET -> DONE, o_tap is held.
REQ-024 On arrival with L<TARGET and o_tap < 2^TAP_W-1 -> o_tap<=o_tap+1, SETTLE.
REQ-025 On arrival with L<TARGET and o_tap = 2^TAP_W-1 -> FAIL; o_tap does not wrap.
REQ-026 Reaching MEASURE index TIMEOUT with i_arrive=0 -> FAIL; o_lat<=TIMEOUT.
REQ-027 DONE: one cycle, o_lock<=1, o_done=1 -> IDLE.
REQ-028 FAIL: one cycle, o_fail<=1, o_done=1 -> IDLE.
REQ-029 o_lock, o_fail, o_tap and o_lat SHALL hold in IDLE until the next accepted i_start.
REQ-030 i_start while o_busy=1 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-031 i_rst=1 at a clock edge SHALL force IDLE and clear o_launch, o_tap, o_lat, o_busy, o_lock, o_fail, o_done and all counters to 0, from any state.
REQ-032 i_rst SHALL take priority over i_start and over every state transition in the same cycle.

Verification
Bench delay model: i_arrive = o_launch delayed by D flops; defaults as listed.
REQ-033 D=o_tap+1, pulse i_start -> o_tap=4, o_lat=5, o_lock=1, o_fail=0, single o_done pulse, 5 launches seen.
REQ-034 D=2 fixed -> 16 launches, then o_fail=1, o_tap=15 (no wrap), o_lat=2, o_lock=0.
REQ-035 i_arrive stuck 1 -> o_fail=1 after SETTLE, o_launch never 1, o_tap=0.
REQ-036 i_arrive stuck 0 -> o_launch high 33 cycles (LAUNCH + 32 MEASURE), o_fail=1, o_lat=32, o_tap=0.
REQ-037 i_rst pulse mid-MEASURE -> next cycle all outputs 0 in IDLE; a subsequent i_start repeats REQ-033 result.
REQ-038 i_start held high through the REQ-033 run -> exactly one calibration until DONE; re-start clears o_lock on the accepting edge.
